// File: rtl/operand_shift_harness.sv
// Serial-load operand shifter for compressor-tree test.
// Loads NUM_OPS operands bit-serially, presents them as a flat bus, registers the
// compressor result and folds every valid result into a MISR signature.
module operand_shift_harness #(
  parameter int unsigned           NUM_OPS   = 23,
  parameter int unsigned           OP_WIDTH  = 23,
  parameter int unsigned           RES_WIDTH = 29,
  parameter logic [RES_WIDTH-1:0]  POLY      = 29'h0000_0005,
  parameter int unsigned           CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          sig_clr,
  input  logic [NUM_OPS-1:0]            ser_in,
  output logic [NUM_OPS*OP_WIDTH-1:0]   ops_flat,
  output logic                          ops_valid,
  input  logic [RES_WIDTH-1:0]          res_in,
  output logic [RES_WIDTH-1:0]          res_q,
  output logic                          res_vld,
  output logic [RES_WIDTH-1:0]          sig,
  output logic [CNT_W-1:0]              sig_cnt
);

  localparam int unsigned FillW = $clog2(OP_WIDTH + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(OP_WIDTH);

  logic [NUM_OPS*OP_WIDTH-1:0] ops_q, ops_d, ops_shifted;
  logic [FillW-1:0]            fill_cnt_q, fill_cnt_d;
  logic                        ops_valid_q, ops_valid_d;
  logic                        shifted_q, shifted_d;
  logic [RES_WIDTH-1:0]        res_q_q;
  logic                        res_vld_q, res_vld_d;
  logic [RES_WIDTH-1:0]        sig_q, sig_d;
  logic [CNT_W-1:0]            sig_cnt_q, sig_cnt_d;

  // Each operand shifts left by one, taking its serial bit into the LSB.
  always_comb begin
    ops_shifted = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      ops_shifted[i*OP_WIDTH +: OP_WIDTH] = {ops_q[i*OP_WIDTH +: OP_WIDTH-1], ser_in[i]};
    end
  end

  // Operand and fill-count next state; clr overrides en.
  always_comb begin
    ops_d      = ops_q;
    fill_cnt_d = fill_cnt_q;
    if (clr) begin
      ops_d      = '0;
      fill_cnt_d = '0;
    end else if (en) begin
      ops_d = ops_shifted;
      if (fill_cnt_q != FillFull) begin
        fill_cnt_d = fill_cnt_q + FillW'(1);
      end
    end
    ops_valid_d = (fill_cnt_d == FillFull);
    shifted_d   = en & ~clr;
    // A result is valid one cycle after a shift that left the operands loaded.
    res_vld_d   = ops_valid_q & shifted_q;
  end

  // MISR fold of the registered result; sig_clr drops a coincident sample.
  always_comb begin
    sig_d     = sig_q;
    sig_cnt_d = sig_cnt_q;
    if (sig_clr) begin
      sig_d     = '0;
      sig_cnt_d = '0;
    end else if (res_vld_q) begin
      sig_d = {sig_q[RES_WIDTH-2:0], 1'b0} ^ (sig_q[RES_WIDTH-1] ? POLY : '0) ^ res_q_q;
      if (sig_cnt_q != '1) begin
        sig_cnt_d = sig_cnt_q + CNT_W'(1);
      end
    end
  end

  // All state registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q       <= '0;
      fill_cnt_q  <= '0;
      ops_valid_q <= 1'b0;
      shifted_q   <= 1'b0;
      res_q_q     <= '0;
      res_vld_q   <= 1'b0;
      sig_q       <= '0;
      sig_cnt_q   <= '0;
    end else begin
      ops_q       <= ops_d;
      fill_cnt_q  <= fill_cnt_d;
      ops_valid_q <= ops_valid_d;
      shifted_q   <= shifted_d;
      res_q_q     <= res_in;
      res_vld_q   <= res_vld_d;
      sig_q       <= sig_d;
      sig_cnt_q   <= sig_cnt_d;
    end
  end

  assign ops_flat  = ops_q;
  assign ops_valid = ops_valid_q;
  assign res_q     = res_q_q;
  assign res_vld   = res_vld_q;
  assign sig       = sig_q;
  assign sig_cnt   = sig_cnt_q;

endmodule

// File: tb/tb_operand_shift_harness.sv
// Bench for operand_shift_harness: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the harness.
module tb_operand_shift_harness;

  localparam int unsigned NOps = 2;
  localparam int unsigned OpW  = 4;
  localparam int unsigned ResW = 8;
  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst, en, clr, sig_clr;
  logic [NOps-1:0] ser_in;
  logic [7:0]      ops_flat;
  logic            ops_valid;
  logic [ResW-1:0] res_in, res_q, sig;
  logic            res_vld;
  logic [CntW-1:0] sig_cnt;

  operand_shift_harness #(
    .NUM_OPS  (NOps),
    .OP_WIDTH (OpW),
    .RES_WIDTH(ResW),
    .POLY     (8'h1D),
    .CNT_W    (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .sig_clr  (sig_clr),
    .ser_in   (ser_in),
    .ops_flat (ops_flat),
    .ops_valid(ops_valid),
    .res_in   (res_in),
    .res_q    (res_q),
    .res_vld  (res_vld),
    .sig      (sig),
    .sig_cnt  (sig_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int m_op[NOps];
  int m_shifts;        // enabled shifts since last rst/clr
  bit m_pending_vld;   // last edge was a shift that left operands loaded
  bit m_vld;
  int m_resq;
  int m_sig;
  int m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int misr_step(input int s, input int r);
    int n;
    n = (s * 2) % 256;
    if (s >= 128) n = n ^ 'h1D;
    return n ^ r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NOps; i++) m_op[i] = 0;
    m_shifts = 0; m_pending_vld = 0; m_vld = 0; m_resq = 0; m_sig = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit r, input bit e, input bit c, input bit sc,
                            input logic [NOps-1:0] s, input logic [7:0] ri);
    if (r) begin
      model_reset();
      return;
    end
    if (sc) begin
      m_sig = 0; m_cnt = 0;
    end else if (m_vld) begin
      m_sig = misr_step(m_sig, m_resq);
      if (m_cnt < 15) m_cnt++;
    end
    m_vld  = m_pending_vld;
    m_resq = int'(ri);
    if (c) begin
      for (int i = 0; i < NOps; i++) m_op[i] = 0;
      m_shifts = 0;
      m_pending_vld = 0;
    end else if (e) begin
      for (int i = 0; i < NOps; i++) m_op[i] = (m_op[i] * 2 + int'(s[i])) % 16;
      m_shifts++;
      m_pending_vld = (m_shifts >= OpW);
    end else begin
      m_pending_vld = 0;
    end
  endtask

  task automatic check_all();
    check("ops_flat", 32'(ops_flat), 32'(m_op[1] * 16 + m_op[0]));
    check("ops_valid", 32'(ops_valid), 32'(m_shifts >= OpW));
    check("res_q", 32'(res_q), 32'(m_resq));
    check("res_vld", 32'(res_vld), 32'(m_vld));
    check("sig", 32'(sig), 32'(m_sig));
    check("sig_cnt", 32'(sig_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cyc(input bit r, input bit e, input bit c, input bit sc,
                     input logic [NOps-1:0] s, input logic [7:0] ri);
    rst = r; en = e; clr = c; sig_clr = sc; ser_in = s; res_in = ri;
    @(posedge clk);
    model_edge(r, e, c, sc, s, ri);
    #1;
    check_all();
  endtask

  logic [7:0] saved_sig;
  logic [3:0] saved_cnt;

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; sig_clr = 1'b0; ser_in = '0; res_in = '0;
    model_reset();

    // 1. Reset
    cyc(1, 0, 0, 0, 2'b00, 8'h00);
    cyc(1, 0, 0, 0, 2'b00, 8'h00);
    check("rst_ops", 32'(ops_flat), 32'h00);
    check("rst_sig", 32'(sig), 32'h00);

    // 2. Fill
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 2'b01, 8'h00);
    check("fill3_valid", 32'(ops_valid), 32'h0);
    cyc(0, 1, 0, 0, 2'b01, 8'h00);
    check("fill4_ops", 32'(ops_flat), 32'h0F);
    check("fill4_valid", 32'(ops_valid), 32'h1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 2'b10, 8'h00);
    check("hold_ops", 32'(ops_flat), 32'h0F);
    check("hold_vld", 32'(res_vld), 32'h0);

    // 3. Shift order into op1: 1,0,1,1 then 0
    cyc(0, 1, 0, 0, 2'b10, 8'h11);
    cyc(0, 1, 0, 0, 2'b00, 8'h22);
    cyc(0, 1, 0, 0, 2'b10, 8'h33);
    cyc(0, 1, 0, 0, 2'b10, 8'h44);
    check("order_b", 32'(ops_flat), 32'hB0);
    cyc(0, 1, 0, 0, 2'b00, 8'h55);
    check("order_6", 32'(ops_flat), 32'h60);

    // 4. clr mid-fill
    cyc(0, 0, 1, 0, 2'b00, 8'h00);
    cyc(0, 0, 0, 0, 2'b00, 8'h00);
    saved_sig = sig; saved_cnt = sig_cnt;
    cyc(0, 1, 0, 0, 2'b11, 8'h00);
    cyc(0, 1, 0, 0, 2'b11, 8'h00);
    cyc(0, 1, 1, 0, 2'b11, 8'h00);
    check("clr_ops", 32'(ops_flat), 32'h00);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 2'b01, 8'h00);
    check("clr_valid3", 32'(ops_valid), 32'h0);
    cyc(0, 1, 0, 0, 2'b01, 8'h00);
    check("clr_valid4", 32'(ops_valid), 32'h1);
    check("clr_sig", 32'(sig), 32'(saved_sig));
    check("clr_cnt", 32'(sig_cnt), 32'(saved_cnt));

    // 5. MISR
    cyc(0, 0, 0, 1, 2'b00, 8'h00);
    cyc(0, 0, 0, 1, 2'b00, 8'h00);
    cyc(0, 1, 0, 0, 2'b01, 8'h00);
    cyc(0, 1, 0, 0, 2'b01, 8'h80);
    cyc(0, 0, 0, 0, 2'b00, 8'h00);
    check("misr_80", 32'(sig), 32'h80);
    cyc(0, 0, 0, 0, 2'b00, 8'h00);
    check("misr_1d", 32'(sig), 32'h1D);
    check("misr_cnt", 32'(sig_cnt), 32'h2);
    cyc(0, 1, 0, 0, 2'b01, 8'h00);
    cyc(0, 0, 0, 1, 2'b00, 8'h5A);
    check("sigclr_vld", 32'(res_vld), 32'h1);
    cyc(0, 0, 0, 1, 2'b00, 8'h00);
    check("sigclr_sig", 32'(sig), 32'h00);
    check("sigclr_cnt", 32'(sig_cnt), 32'h0);

    // 6. Saturation then reset with en high
    for (int i = 0; i < 22; i++) cyc(0, 1, 0, 0, 2'($urandom), 8'($urandom));
    check("sat_cnt", 32'(sig_cnt), 32'hF);
    cyc(1, 1, 0, 0, 2'b11, 8'hFF);
    check("rst_ops2", 32'(ops_flat), 32'h00);
    check("rst_valid2", 32'(ops_valid), 32'h0);
    check("rst_vld2", 32'(res_vld), 32'h0);
    check("rst_sig2", 32'(sig), 32'h00);
    check("rst_cnt2", 32'(sig_cnt), 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0),
          2'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
